// File: rtl/times_timer_pkg.sv
// Shared constants and types for the times_timer countdown peripheral:
// register word addresses, CTRL field positions and the FSM state encoding.
package times_pkg;

    // Word addresses decoded from ADD_I[3:2]
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_UNUSED = 2'd3;

    // CTRL field positions; only the low four bits are implemented
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_WIDTH   = 4;

    // Mode encoding; every value other than auto-reload behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // Timer sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/times_timer.sv
// Memory-mapped 32-bit countdown timer with CTRL / PRESET / COUNT registers.
// Counts down from PRESET, raises a maskable level interrupt on expiry and
// either stops (one-shot) or reloads and restarts (auto-reload).
module times_timer
    import times_pkg::*;
(
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [3:2]  ADD_I,
    input  logic        WE_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        IRQ
);

    timer_state_t              state;
    timer_state_t              state_next;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic [CTRL_WIDTH-1:0]     ctrl_next;
    logic [31:0]               preset;
    logic [31:0]               preset_next;
    logic [31:0]               count;
    logic [31:0]               count_next;
    logic                      irq_flag;
    logic                      irq_flag_next;
    logic                      irq_set;
    logic                      reload_mode;

    assign reload_mode = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    // Register all state; synchronous reset returns every register to zero
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_flag <= irq_flag_next;
        end
    end

    // Next-state logic: hardware sequencing first, then bus writes layered on
    // top so a CTRL write beats the hardware Enable clear, and a fresh expiry
    // beats the write-side clear of irq_flag
    always_comb begin
        state_next    = state;
        ctrl_next     = ctrl;
        preset_next   = preset;
        count_next    = count;
        irq_flag_next = irq_flag;
        irq_set       = 1'b0;

        case (state)
            IDLE: begin
                if (ctrl[CTRL_EN]) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    count_next = '0;
                    irq_set    = 1'b1;
                    state_next = INT;
                end
            end
            INT: begin
                if (reload_mode) begin
                    irq_flag_next = 1'b0;
                    state_next    = LOAD;
                end else begin
                    ctrl_next[CTRL_EN] = 1'b0;
                    state_next         = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (WE_I) begin
            case (ADD_I)
                ADDR_CTRL: begin
                    ctrl_next     = DAT_I[CTRL_WIDTH-1:0];
                    irq_flag_next = 1'b0;
                end
                ADDR_PRESET: begin
                    preset_next   = DAT_I;
                    irq_flag_next = 1'b0;
                end
                default: begin
                end
            endcase
        end

        if (irq_set) begin
            irq_flag_next = 1'b1;
        end
    end

    // Combinational read mux; unimplemented CTRL bits and address 3 read as 0
    always_comb begin
        DAT_O = '0;
        case (ADD_I)
            ADDR_CTRL:   DAT_O = {{(32-CTRL_WIDTH){1'b0}}, ctrl};
            ADDR_PRESET: DAT_O = preset;
            ADDR_COUNT:  DAT_O = count;
            ADDR_UNUSED: DAT_O = '0;
            default:     DAT_O = '0;
        endcase
    end

    assign IRQ = ctrl[CTRL_IM] & irq_flag;

endmodule

// File: tb/tb_times_timer.sv
// Scoreboard bench for times_timer: a behavioural model predicts the register
// read-back and IRQ after every clock edge, a monitor compares the DUT.
module tb_times_timer;

    logic        clk;
    logic        rstIn;
    logic [1:0]  addrIn;
    logic        weIn;
    logic [31:0] datIn;
    logic [31:0] datOut;
    logic        irqOut;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] dat;
        logic        irq;
    } exp_t;

    exp_t expQ[$];
    int   vectors;
    int   miscompares;

    // Behavioural model state: registers plus a description of the running
    // countdown as "preset loaded" and "edges elapsed since the load"
    bit [3:0]  mCtrl;
    bit [31:0] mPreset;
    bit [31:0] mCount;
    bit        mFlag;
    bit        mLoadPending;
    bit        mActive;
    bit        mIntPending;
    longint    mLoaded;
    longint    mElapsed;

    times_timer dut (
        .CLK_I (clk),
        .RST_I (rstIn),
        .ADD_I (addrIn),
        .WE_I  (weIn),
        .DAT_I (datIn),
        .DAT_O (datOut),
        .IRQ   (irqOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit [31:0] modelRead(input bit [1:0] a);
        case (a)
            2'd0:    return {28'd0, mCtrl};
            2'd1:    return mPreset;
            2'd2:    return mCount;
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the model, using the inputs stable across the edge
    task automatic modelStep();
        bit    oldEn;
        bit    setNow;
        exp_t  e;
        if (rstIn) begin
            mCtrl = '0; mPreset = '0; mCount = '0; mFlag = 0;
            mLoadPending = 0; mActive = 0; mIntPending = 0;
            mLoaded = 0; mElapsed = 0;
        end else begin
            oldEn  = mCtrl[0];
            setNow = 0;
            if (mIntPending) begin
                mIntPending = 0;
                if (mCtrl[2:1] == 2'd1) begin
                    mFlag        = 0;
                    mLoadPending = 1;
                end else begin
                    mCtrl[0] = 0;
                end
            end else if (mActive) begin
                if (!oldEn) begin
                    mActive = 0;
                end else begin
                    mElapsed++;
                    if (mElapsed >= ((mLoaded == 0) ? 1 : mLoaded)) begin
                        mCount      = 0;
                        mFlag       = 1;
                        setNow      = 1;
                        mActive     = 0;
                        mIntPending = 1;
                    end else begin
                        mCount = 32'(mLoaded - mElapsed);
                    end
                end
            end else if (mLoadPending) begin
                mLoadPending = 0;
                mLoaded      = longint'(mPreset);
                mCount       = mPreset;
                mElapsed     = 0;
                mActive      = 1;
            end else if (oldEn) begin
                mLoadPending = 1;
            end
            if (weIn && addrIn == 2'd0) begin
                mCtrl = datIn[3:0];
                if (!setNow) mFlag = 0;
            end
            if (weIn && addrIn == 2'd1) begin
                mPreset = datIn;
                if (!setNow) mFlag = 0;
            end
        end
        e.addr = addrIn;
        e.dat  = modelRead(addrIn);
        e.irq  = mCtrl[3] & mFlag;
        expQ.push_back(e);
    endtask

    // Pop the prediction for this edge and compare it with the DUT
    task automatic checkOutput();
        exp_t e;
        e = expQ.pop_front();
        vectors++;
        if (datOut !== e.dat) begin
            miscompares++;
            $display("[TB] FAIL dat_o addr=%0d @%0t: actual %h, required %h",
                     e.addr, $time, datOut, e.dat);
        end
        vectors++;
        if (irqOut !== e.irq) begin
            miscompares++;
            $display("[TB] FAIL irq @%0t: actual %b, required %b",
                     $time, irqOut, e.irq);
        end
    endtask

    // Model runs at every edge and pushes the expected read-back
    always @(posedge clk) begin
        modelStep();
    end

    // Monitor samples the DUT just after each edge
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) checkOutput();
    end

    task automatic applyStimulus(input bit we, input bit [1:0] a,
                                 input bit [31:0] d, input bit r);
        @(negedge clk);
        weIn   = we;
        addrIn = a;
        datIn  = d;
        rstIn  = r;
    endtask

    task automatic idleRead(input bit [1:0] a, input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, a, $urandom, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstIn  = 1'b1;
        weIn   = 1'b0;
        addrIn = 2'd0;
        datIn  = '0;

        // Reset, then read every address
        applyStimulus(0, 2'd0, 0, 1);
        applyStimulus(0, 2'd0, 0, 1);
        for (int a = 0; a < 4; a++) applyStimulus(0, 2'(a), 32'hA5A5A5A5, 0);

        // One-shot with interrupt enabled, then clear by CTRL write
        applyStimulus(1, 2'd1, 32'd3, 0);
        applyStimulus(1, 2'd0, 32'h9, 0);
        idleRead(2'd2, 8);
        idleRead(2'd0, 2);
        applyStimulus(1, 2'd0, 32'h0, 0);
        idleRead(2'd0, 2);

        // Auto-reload with interrupt enabled
        applyStimulus(1, 2'd1, 32'd3, 0);
        applyStimulus(1, 2'd0, 32'hB, 0);
        idleRead(2'd2, 16);
        applyStimulus(1, 2'd0, 32'h0, 0);
        idleRead(2'd2, 3);

        // One-shot with interrupt masked
        applyStimulus(1, 2'd0, 32'h1, 0);
        idleRead(2'd2, 7);
        idleRead(2'd0, 2);

        // Disable mid-count holds COUNT, re-enable reloads
        applyStimulus(1, 2'd1, 32'd10, 0);
        applyStimulus(1, 2'd0, 32'h9, 0);
        idleRead(2'd2, 5);
        applyStimulus(1, 2'd0, 32'h8, 0);
        idleRead(2'd2, 4);
        applyStimulus(1, 2'd0, 32'h9, 0);
        idleRead(2'd2, 6);
        applyStimulus(1, 2'd0, 32'h0, 0);

        // Upper CTRL bits, COUNT write ignored, reset mid-count
        applyStimulus(1, 2'd0, 32'hFFFFFFFF, 0);
        idleRead(2'd0, 1);
        applyStimulus(1, 2'd0, 32'h0, 0);
        applyStimulus(1, 2'd1, 32'd8, 0);
        applyStimulus(1, 2'd0, 32'h9, 0);
        idleRead(2'd2, 4);
        applyStimulus(1, 2'd2, 32'h55, 0);
        idleRead(2'd2, 1);
        applyStimulus(1, 2'd3, 32'h77, 0);
        applyStimulus(0, 2'd2, 0, 1);
        for (int a = 0; a < 4; a++) applyStimulus(0, 2'(a), 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit [1:0]  a;
            bit [31:0] d;
            bit        we;
            bit        r;
            a  = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 299) == 0);
            d  = $urandom;
            if (we && a == 2'd1) d = $urandom_range(1, 12);
            if (we && a == 2'd0) d = {d[31:4], 1'b1, d[2:0]};
            if (we && a == 2'd0 && $urandom_range(0, 3) == 0) d[0] = 1'b0;
            applyStimulus(we, a, d, r);
        end

        applyStimulus(0, 2'd0, 0, 0);
        applyStimulus(0, 2'd0, 0, 0);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: actual %0d entries, required 0",
                     expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
